// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - FIFO request/response and RAM-side signal bundle for ram_fifo_ctrl
interface ram_fifo_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          PUSH;
  logic [DW-1:0] PUSH_DATA;
  logic          POP;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   COUNT;
  logic          OVERFLOW;
  logic          UNDERFLOW;
  logic          RAM_WE;
  logic [AW-1:0] RAM_WA;
  logic [DW-1:0] RAM_WD;
  logic          RAM_RE;
  logic [AW-1:0] RAM_RA;
  logic [DW-1:0] RAM_Q;

  modport master (
    output PUSH, PUSH_DATA, POP, RAM_Q,
    input  DOUT, DOUT_VALID, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW,
    input  RAM_WE, RAM_WA, RAM_WD, RAM_RE, RAM_RA
  );

  modport slave (
    input  PUSH, PUSH_DATA, POP, RAM_Q,
    output DOUT, DOUT_VALID, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW,
    output RAM_WE, RAM_WA, RAM_WD, RAM_RE, RAM_RA
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - turns a 2**AW-word posedge-write/comb-read RAM into a FIFO
module ram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input logic           CLK,
  input logic           RST_N,
  ram_fifo_ctrl_if.slave bus
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [DW-1:0] dout_q;
  logic          valid_q;
  logic          ovf_q;
  logic          unf_q;
  logic          pop_ok;
  logic          push_ok;

  // A pop on a full FIFO frees the slot the push lands in on the same edge.
  always_comb begin
    pop_ok  = RST_N && bus.POP && (count != '0);
    push_ok = RST_N && bus.PUSH && ((count != DEPTH) || pop_ok);
  end

  assign bus.RAM_WE     = push_ok;
  assign bus.RAM_WA     = wptr;
  assign bus.RAM_WD     = bus.PUSH_DATA;
  assign bus.RAM_RE     = pop_ok;
  assign bus.RAM_RA     = rptr;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = valid_q;
  assign bus.FULL       = (count == DEPTH);
  assign bus.EMPTY      = (count == '0);
  assign bus.COUNT      = count;
  assign bus.OVERFLOW   = ovf_q;
  assign bus.UNDERFLOW  = unf_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      // RAM_Q is only meaningful while RAM_RE is high, i.e. when pop_ok.
      if (pop_ok) begin
        dout_q <= bus.RAM_Q;
        rptr   <= rptr + 1'b1;
      end
      valid_q <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.PUSH && !push_ok) begin
        ovf_q <= 1'b1;
      end
      if (bus.POP && !pop_ok) begin
        unf_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed scoreboard bench for ram_fifo_ctrl with a behavioural RAM
module tb_ram_fifo_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] sb[$];
  int         mcnt;
  logic       movf;
  logic       munf;
  logic [7:0] mdout;
  logic [7:0] mem[16];

  ram_fifo_ctrl_if #(.DW(8), .AW(4)) bus();

  ram_fifo_ctrl #(.DW(8), .AW(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge-write, combinational-read RAM; junk on Q while RE is low.
  always @(posedge clk) begin
    if (bus.RAM_WE) mem[bus.RAM_WA] <= bus.RAM_WD;
  end
  assign bus.RAM_Q = bus.RAM_RE ? mem[bus.RAM_RA] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    logic [7:0] got;
    if (bus.DOUT_VALID === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got   = sb.pop_front();
        mdout = got;
      end
    end
    chk("dout", 32'(bus.DOUT), 32'(mdout));
    chk("count", 32'(bus.COUNT), 32'(mcnt));
    chk("full", 32'(bus.FULL), 32'(mcnt == 16));
    chk("empty", 32'(bus.EMPTY), 32'(mcnt == 0));
    chk("overflow", 32'(bus.OVERFLOW), 32'(movf));
    chk("underflow", 32'(bus.UNDERFLOW), 32'(munf));
  endtask

  task automatic cycle(input logic p, input logic [7:0] d, input logic q);
    logic pop_ok;
    logic push_ok;
    @(negedge clk);
    bus.PUSH = p;
    bus.PUSH_DATA = d;
    bus.POP = q;
    pop_ok  = q && (mcnt != 0);
    push_ok = p && ((mcnt != 16) || pop_ok);
    #1;
    chk("ram_we", 32'(bus.RAM_WE), 32'(push_ok));
    chk("ram_re", 32'(bus.RAM_RE), 32'(pop_ok));
    if (push_ok) begin
      chk("ram_wd", 32'(bus.RAM_WD), 32'(d));
      sb.push_back(d);
    end
    mcnt = mcnt + int'(push_ok) - int'(pop_ok);
    if (p && !push_ok) movf = 1'b1;
    if (q && !pop_ok) munf = 1'b1;
    @(posedge clk);
    #1;
    chk("dout_valid", 32'(bus.DOUT_VALID), 32'(pop_ok));
    check_regs();
  endtask

  task automatic do_reset(input logic p, input logic q);
    @(negedge clk);
    rst_n = 1'b0;
    bus.PUSH = p;
    bus.PUSH_DATA = 8'hBB;
    bus.POP = q;
    #1;
    chk("rst_ram_we", 32'(bus.RAM_WE), 32'd0);
    chk("rst_ram_re", 32'(bus.RAM_RE), 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    mcnt = 0; movf = 1'b0; munf = 1'b0; mdout = 8'h00;
    chk("rst_dout_valid", 32'(bus.DOUT_VALID), 32'd0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    bus.PUSH = 1'b0;
    bus.POP = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    mcnt = 0; movf = 1'b0; munf = 1'b0; mdout = 8'h00;
    rst_n = 1'b0;
    bus.PUSH = 1'b0; bus.PUSH_DATA = 8'h00; bus.POP = 1'b0;

    do_reset(1'b0, 1'b0);
    do_reset(1'b1, 1'b1);

    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    repeat (16) cycle(1'b0, 8'h00, 1'b1);

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'h5A, 1'b1);
    repeat (16) cycle(1'b0, 8'h00, 1'b1);
    chk("last_byte", 32'(mdout), 32'h5A);

    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h77, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("post_reset_data", 32'(mdout), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
